// File: rtl/multicore_pkg.sv
// Shared types for the branch unit: branch function encodings, the
// resolved-branch result record and a legality helper.
package multicore_pkg;

    localparam int DATA_SIZE = 32;

    // Sequential next PC is always the branch PC plus one 32-bit instruction.
    localparam int PC_STEP = 4;

    // Branch function field; 3'b010 and 3'b011 are reserved encodings.
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } t_brop;

    // One resolved branch as held in the output stage.
    typedef struct packed {
        logic                 taken;
        logic [DATA_SIZE-1:0] next_pc;
        logic                 mispredict;
        logic                 illegal;
    } t_br_result;

    // True for every encoding that names a real branch function.
    function automatic logic brop_is_legal(input logic [2:0] funct);
        return (funct != 3'b010) && (funct != 3'b011);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch evaluation: direction, next PC and mispredict flag
// for one request. WIDTH must not exceed DATA_SIZE (the result record is
// DATA_SIZE wide and the PC is zero-extended into it).
module branch_cond_eval
    import multicore_pkg::*;
#(
    parameter int WIDTH = DATA_SIZE
) (
    input  t_brop            i_funct,
    input  logic [WIDTH-1:0] i_r1,
    input  logic [WIDTH-1:0] i_r2,
    input  logic [WIDTH-1:0] i_pc,
    input  logic [WIDTH-1:0] i_imm,
    input  logic             i_pred_taken,
    input  logic [WIDTH-1:0] i_pred_target,
    output t_br_result       o_result
);

    logic             legal;
    logic             eq;
    logic             lt_s;
    logic             lt_u;
    logic             taken;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] next_pc;

    // Evaluate the condition; reserved encodings resolve as not taken and
    // never report a mispredict. PC arithmetic wraps modulo 2^WIDTH.
    always_comb begin
        legal   = brop_is_legal(i_funct);
        eq      = (i_r1 == i_r2);
        lt_s    = ($signed(i_r1) < $signed(i_r2));
        lt_u    = (i_r1 < i_r2);
        taken   = 1'b0;
        case (i_funct)
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = !eq;
            BR_BLT:  taken = lt_s;
            BR_BGE:  taken = !lt_s;
            BR_BLTU: taken = lt_u;
            BR_BGEU: taken = !lt_u;
            default: taken = 1'b0;
        endcase
        target  = i_pc + i_imm;
        seq_pc  = i_pc + WIDTH'(PC_STEP);
        next_pc = taken ? target : seq_pc;

        o_result            = '0;
        o_result.taken      = taken;
        o_result.next_pc    = DATA_SIZE'(next_pc);
        o_result.illegal    = !legal;
        o_result.mispredict = legal &&
                              ((taken != i_pred_taken) ||
                               (taken && (target != i_pred_target)));
    end

endmodule

// File: rtl/branch_resolve.sv
// Two-stage branch resolution pipe. S1 registers the request operands,
// branch_cond_eval resolves them, S2 registers the result. Statistics
// counters advance only when a result leaves S2.
//
// Handshake: an input request transfers on a cycle where i_valid && o_ready;
// a result transfers on a cycle where o_valid && i_ready. A stage advances
// when it is empty or its downstream stage advances, so the pipe sustains
// one transfer per cycle. o_ready is low during reset and during flush.
module branch_resolve
    import multicore_pkg::*;
#(
    parameter int WIDTH = DATA_SIZE,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  t_brop            i_funct,
    input  logic [WIDTH-1:0] i_r1,
    input  logic [WIDTH-1:0] i_r2,
    input  logic [WIDTH-1:0] i_pc,
    input  logic [WIDTH-1:0] i_imm,
    input  logic             i_pred_taken,
    input  logic [WIDTH-1:0] i_pred_target,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_taken,
    output logic [WIDTH-1:0] o_next_pc,
    output logic             o_mispredict,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_br_count,
    output logic [CNT_W-1:0] o_mp_count
);

    // S1: operand register
    logic             s1_valid_q, s1_valid_d;
    t_brop            s1_funct_q, s1_funct_d;
    logic [WIDTH-1:0] s1_r1_q, s1_r1_d;
    logic [WIDTH-1:0] s1_r2_q, s1_r2_d;
    logic [WIDTH-1:0] s1_pc_q, s1_pc_d;
    logic [WIDTH-1:0] s1_imm_q, s1_imm_d;
    logic             s1_pred_taken_q, s1_pred_taken_d;
    logic [WIDTH-1:0] s1_pred_target_q, s1_pred_target_d;

    // S2: result register
    logic             s2_valid_q, s2_valid_d;
    t_br_result       s2_res_q, s2_res_d;

    // Statistics
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mp_count_q, mp_count_d;

    // Pipe control
    logic             s1_adv;
    logic             s2_adv;
    logic             accept;
    logic             out_hs;
    t_br_result       eval_res;

    branch_cond_eval #(
        .WIDTH (WIDTH)
    ) u_cond_eval (
        .i_funct       (s1_funct_q),
        .i_r1          (s1_r1_q),
        .i_r2          (s1_r2_q),
        .i_pc          (s1_pc_q),
        .i_imm         (s1_imm_q),
        .i_pred_taken  (s1_pred_taken_q),
        .i_pred_target (s1_pred_target_q),
        .o_result      (eval_res)
    );

    // Stage advance, handshakes, next-state of both stages and the counters.
    always_comb begin
        s2_adv  = !s2_valid_q || i_ready;
        s1_adv  = !s1_valid_q || s2_adv;
        o_ready = !i_rst && !i_flush && s1_adv;
        accept  = i_valid && o_ready;
        out_hs  = s2_valid_q && i_ready;

        s1_valid_d       = s1_valid_q;
        s1_funct_d       = s1_funct_q;
        s1_r1_d          = s1_r1_q;
        s1_r2_d          = s1_r2_q;
        s1_pc_d          = s1_pc_q;
        s1_imm_d         = s1_imm_q;
        s1_pred_taken_d  = s1_pred_taken_q;
        s1_pred_target_d = s1_pred_target_q;
        s2_valid_d       = s2_valid_q;
        s2_res_d         = s2_res_q;
        br_count_d       = br_count_q;
        mp_count_d       = mp_count_q;

        if (i_flush) begin
            s1_valid_d = 1'b0;
        end else if (s1_adv) begin
            s1_valid_d = accept;
        end
        if (accept) begin
            s1_funct_d       = i_funct;
            s1_r1_d          = i_r1;
            s1_r2_d          = i_r2;
            s1_pc_d          = i_pc;
            s1_imm_d         = i_imm;
            s1_pred_taken_d  = i_pred_taken;
            s1_pred_target_d = i_pred_target;
        end

        if (i_flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        // The result register only changes when S2 takes a new entry, which
        // keeps every output steady while the consumer stalls.
        if (!i_flush && s2_adv && s1_valid_q) begin
            s2_res_d = eval_res;
        end

        // A handshake in a flush cycle still counts; flushed entries never do.
        if (out_hs) begin
            if (!s2_res_q.illegal && (br_count_q != {CNT_W{1'b1}})) begin
                br_count_d = br_count_q + 1'b1;
            end
            if (s2_res_q.mispredict && (mp_count_q != {CNT_W{1'b1}})) begin
                mp_count_d = mp_count_q + 1'b1;
            end
        end
    end

    // State registers; reset wins over flush and any handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q       <= 1'b0;
            s1_funct_q       <= BR_BEQ;
            s1_r1_q          <= '0;
            s1_r2_q          <= '0;
            s1_pc_q          <= '0;
            s1_imm_q         <= '0;
            s1_pred_taken_q  <= 1'b0;
            s1_pred_target_q <= '0;
            s2_valid_q       <= 1'b0;
            s2_res_q         <= '0;
            br_count_q       <= '0;
            mp_count_q       <= '0;
        end else begin
            s1_valid_q       <= s1_valid_d;
            s1_funct_q       <= s1_funct_d;
            s1_r1_q          <= s1_r1_d;
            s1_r2_q          <= s1_r2_d;
            s1_pc_q          <= s1_pc_d;
            s1_imm_q         <= s1_imm_d;
            s1_pred_taken_q  <= s1_pred_taken_d;
            s1_pred_target_q <= s1_pred_target_d;
            s2_valid_q       <= s2_valid_d;
            s2_res_q         <= s2_res_d;
            br_count_q       <= br_count_d;
            mp_count_q       <= mp_count_d;
        end
    end

    // Output view of S2 and the counters.
    always_comb begin
        o_valid      = s2_valid_q;
        o_taken      = s2_res_q.taken;
        o_next_pc    = s2_res_q.next_pc[WIDTH-1:0];
        o_mispredict = s2_res_q.mispredict;
        o_illegal    = s2_res_q.illegal;
        o_br_count   = br_count_q;
        o_mp_count   = mp_count_q;
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: a table of single-branch vectors with
// hand-computed results, then stall, flush, reset and saturation sequences.
module tb_branch_resolve;
    import multicore_pkg::*;

    localparam int W  = 32;
    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    t_brop         i_funct;
    logic [W-1:0]  i_r1, i_r2, i_pc, i_imm, i_pred_target;
    logic          i_pred_taken;
    logic          i_flush;
    logic          o_valid;
    logic          i_ready;
    logic          o_taken;
    logic [W-1:0]  o_next_pc;
    logic          o_mispredict;
    logic          o_illegal;
    logic [CW-1:0] o_br_count, o_mp_count;

    branch_resolve #(.WIDTH(W), .CNT_W(CW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_funct(i_funct), .i_r1(i_r1), .i_r2(i_r2), .i_pc(i_pc),
        .i_imm(i_imm), .i_pred_taken(i_pred_taken),
        .i_pred_target(i_pred_target), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_taken(o_taken),
        .o_next_pc(o_next_pc), .o_mispredict(o_mispredict),
        .o_illegal(o_illegal), .o_br_count(o_br_count),
        .o_mp_count(o_mp_count)
    );

    // Clock
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]   funct;
        logic [W-1:0] r1, r2, pc, imm;
        logic         pt;
        logic [W-1:0] ptgt;
        logic         e_taken;
        logic [W-1:0] e_npc;
        logic         e_mp;
        logic         e_ill;
    } vec_t;

    vec_t         vecs[12];
    logic [W:0]   exp_q[$];
    int           errors = 0;
    int           checks = 0;
    int           br_exp, mp_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic idle_inputs();
        i_valid = 1'b0; i_flush = 1'b0; i_funct = BR_BEQ;
        i_r1 = '0; i_r2 = '0; i_pc = '0; i_imm = '0;
        i_pred_taken = 1'b0; i_pred_target = '0;
    endtask

    task automatic drive(input vec_t v);
        i_valid = 1'b1; i_funct = t_brop'(v.funct);
        i_r1 = v.r1; i_r2 = v.r2; i_pc = v.pc; i_imm = v.imm;
        i_pred_taken = v.pt; i_pred_target = v.ptgt;
    endtask

    task automatic reset_dut();
        tick();
        idle_inputs();
        i_rst = 1'b1; i_ready = 1'b1;
        tick();
        #1 check("ready_in_reset", o_ready, 0);
        tick();
        i_rst = 1'b0;
        #1;
    endtask

    function automatic int sat(input int x);
        return (x > int'(CMAX)) ? int'(CMAX) : x;
    endfunction

    vec_t v;
    logic [W-1:0] pc_v;
    logic         tk_v;
    logic         prev_stall;
    logic [W-1:0] prev_npc;
    logic         prev_tk, prev_mp;
    logic [W:0]   exp_item;
    int           sent, got;

    initial begin
        //              funct   r1            r2            pc            imm           pt    ptgt          tk    npc           mp    ill
        vecs[0]  = '{3'b100, 32'hFFFFFFFF, 32'h1,        32'h100,      32'h20,       1'b0, 32'h0,        1'b1, 32'h120,      1'b1, 1'b0};
        vecs[1]  = '{3'b110, 32'hFFFFFFFF, 32'h1,        32'h100,      32'h20,       1'b0, 32'h0,        1'b0, 32'h104,      1'b0, 1'b0};
        vecs[2]  = '{3'b000, 32'h5,        32'h5,        32'h200,      32'h10,       1'b1, 32'h210,      1'b1, 32'h210,      1'b0, 1'b0};
        vecs[3]  = '{3'b001, 32'h5,        32'h5,        32'h200,      32'h10,       1'b1, 32'h210,      1'b0, 32'h204,      1'b1, 1'b0};
        vecs[4]  = '{3'b101, 32'hFFFFFFFF, 32'h1,        32'h300,      32'h8,        1'b0, 32'h0,        1'b0, 32'h304,      1'b0, 1'b0};
        vecs[5]  = '{3'b111, 32'hFFFFFFFF, 32'h1,        32'h300,      32'h8,        1'b0, 32'h0,        1'b1, 32'h308,      1'b1, 1'b0};
        vecs[6]  = '{3'b101, 32'h7,        32'h7,        32'h400,      32'hFFFFFFF0, 1'b1, 32'h0,        1'b1, 32'h3F0,      1'b1, 1'b0};
        vecs[7]  = '{3'b000, 32'h1,        32'h2,        32'hFFFFFFFC, 32'h40,       1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
        vecs[8]  = '{3'b010, 32'h3,        32'h3,        32'h500,      32'h40,       1'b1, 32'h540,      1'b0, 32'h504,      1'b0, 1'b1};
        vecs[9]  = '{3'b011, 32'h3,        32'h4,        32'h600,      32'h40,       1'b0, 32'h0,        1'b0, 32'h604,      1'b0, 1'b1};
        vecs[10] = '{3'b110, 32'h1,        32'hFFFFFFFF, 32'h700,      32'h40,       1'b1, 32'h740,      1'b1, 32'h740,      1'b0, 1'b0};
        vecs[11] = '{3'b001, 32'h1,        32'h2,        32'hFFFFFFF0, 32'h20,       1'b1, 32'h10,       1'b1, 32'h10,       1'b0, 1'b0};

        idle_inputs();
        i_rst = 1'b1; i_ready = 1'b1;
        reset_dut();
        check("rst_o_valid", o_valid, 0);
        check("rst_o_taken", o_taken, 0);
        check("rst_o_next_pc", o_next_pc, 0);
        check("rst_o_mispredict", o_mispredict, 0);
        check("rst_o_illegal", o_illegal, 0);
        check("rst_br_count", o_br_count, 0);
        check("rst_mp_count", o_mp_count, 0);

        // Table: one request at a time, latency and result checks.
        br_exp = 0; mp_exp = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            drive(vecs[k]);
            #1 check($sformatf("v%0d_ready", k), o_ready, 1);
            tick();
            idle_inputs();
            #1 check($sformatf("v%0d_lat1_valid", k), o_valid, 0);
            tick();
            #1;
            check($sformatf("v%0d_lat2_valid", k), o_valid, 1);
            check($sformatf("v%0d_taken", k), o_taken, vecs[k].e_taken);
            check($sformatf("v%0d_next_pc", k), o_next_pc, vecs[k].e_npc);
            check($sformatf("v%0d_mispredict", k), o_mispredict, vecs[k].e_mp);
            check($sformatf("v%0d_illegal", k), o_illegal, vecs[k].e_ill);
            if (!vecs[k].e_ill) br_exp = sat(br_exp + 1);
            if (vecs[k].e_mp) mp_exp = sat(mp_exp + 1);
            tick();
            #1;
            check($sformatf("v%0d_br_count", k), o_br_count, br_exp[CW-1:0]);
            check($sformatf("v%0d_mp_count", k), o_mp_count, mp_exp[CW-1:0]);
        end

        // Back-to-back BEQ stream with a consumer stall.
        reset_dut();
        sent = 0; got = 0; prev_stall = 1'b0;
        prev_npc = '0; prev_tk = 1'b0; prev_mp = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            tick();
            i_ready = !(cyc >= 3 && cyc <= 5);
            if (sent < 8) begin
                v = '{3'b000, W'(sent), W'(sent + (sent % 2)), W'(32'h1000 + 16 * sent),
                      32'h8, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
                drive(v);
            end else begin
                idle_inputs();
            end
            #1;
            if (prev_stall) begin
                check("stall_valid_held", o_valid, 1);
                check("stall_next_pc_held", o_next_pc, prev_npc);
                check("stall_taken_held", o_taken, prev_tk);
                check("stall_mp_held", o_mispredict, prev_mp);
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("stall_unexpected_output", 1, 0);
                end else begin
                    exp_item = exp_q.pop_front();
                    check($sformatf("stall_item%0d", got), {o_taken, o_next_pc}, exp_item);
                end
                got++;
            end
            if (i_valid && o_ready) begin
                pc_v = W'(32'h1000 + 16 * sent);
                tk_v = ((sent % 2) == 0);
                exp_q.push_back({tk_v, tk_v ? pc_v + 32'h8 : pc_v + 32'h4});
                sent++;
            end
            prev_stall = o_valid && !i_ready;
            prev_npc = o_next_pc; prev_tk = o_taken; prev_mp = o_mispredict;
        end
        check("stall_all_received", got, 8);
        tick();
        idle_inputs();
        i_ready = 1'b1;
        #1;
        check("stall_br_count", o_br_count, 8);
        check("stall_mp_count", o_mp_count, 4);

        // Flush with both stages full; a request offered during flush is refused.
        reset_dut();
        tick(); i_ready = 1'b0; drive(vecs[0]);
        tick(); drive(vecs[2]);
        tick(); drive(vecs[3]); i_flush = 1'b1;
        #1;
        check("flush_pipe_full", o_valid, 1);
        check("flush_ready_low", o_ready, 0);
        tick(); idle_inputs(); i_ready = 1'b1;
        #1;
        check("flush_valid_cleared", o_valid, 0);
        check("flush_br_unchanged", o_br_count, 0);
        check("flush_mp_unchanged", o_mp_count, 0);
        tick(); tick();
        #1;
        check("flush_no_late_output", o_valid, 0);
        check("flush_br_still_zero", o_br_count, 0);

        // Flush coinciding with an output handshake: the handshake counts.
        tick(); drive(vecs[0]);
        tick(); idle_inputs();
        tick();
        #1 check("flush_hs_valid", o_valid, 1);
        i_flush = 1'b1;
        tick(); i_flush = 1'b0;
        #1;
        check("flush_hs_valid_cleared", o_valid, 0);
        check("flush_hs_br_count", o_br_count, 1);
        check("flush_hs_mp_count", o_mp_count, 1);

        // Reset in the middle of a stream.
        tick(); i_ready = 1'b0; drive(vecs[5]);
        tick(); drive(vecs[6]);
        tick(); idle_inputs(); i_ready = 1'b1; i_rst = 1'b1;
        #1 check("midrst_ready_low", o_ready, 0);
        tick(); i_rst = 1'b0;
        #1;
        check("midrst_o_valid", o_valid, 0);
        check("midrst_o_taken", o_taken, 0);
        check("midrst_o_next_pc", o_next_pc, 0);
        check("midrst_o_mispredict", o_mispredict, 0);
        check("midrst_br_count", o_br_count, 0);
        check("midrst_mp_count", o_mp_count, 0);
        tick(); tick();
        #1 check("midrst_no_output", o_valid, 0);

        // Counter saturation: fill mp_count, then one more mispredict.
        reset_dut();
        for (int k = 0; k < int'(CMAX); k++) begin
            tick(); drive(vecs[3]);
        end
        tick(); idle_inputs();
        tick(); tick(); tick();
        #1;
        check("sat_mp_full", o_mp_count, CMAX);
        check("sat_br_full", o_br_count, CMAX);
        tick(); drive(vecs[3]);
        tick(); idle_inputs();
        tick(); tick(); tick();
        #1;
        check("sat_mp_held", o_mp_count, CMAX);
        check("sat_br_held", o_br_count, CMAX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter WIDTH, default DATA_SIZE: operand and PC width in bits.
REQ-002 Parameter CNT_W, default 16: width of each statistics counter.
REQ-003 i_clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_valid  input  1  request valid.
REQ-006 o_ready  output  1  request accepted when i_valid and o_ready are both high.
REQ-007 i_funct  input  t_brop  branch function (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111).
REQ-008 i_r1, i_r2  input  WIDTH each  source operands.
REQ-009 i_pc  input  WIDTH  branch PC.
REQ-010 i_imm  input  WIDTH  sign-extended branch offset.
REQ-011 i_pred_taken  input  1  predicted direction.
REQ-012 i_pred_target  input  WIDTH  predicted target.
REQ-013 i_flush  input  1  discards every in-flight request.
REQ-014 o_valid  output  1  result valid.
REQ-015 i_ready  input  1  result consumed when o_valid and i_ready are both high.
REQ-016 o_taken  output  1  resolved branch direction.
REQ-017 o_next_pc  output  WIDTH  correct next PC.
REQ-018 o_mispredict  output  1  prediction was wrong.
REQ-019 o_illegal  output  1  i_funct is 010 or 011.
REQ-020 o_br_count, o_mp_count  output  CNT_W each  resolved-branch count and mispredict count.

Function
REQ-021 Pipeline: two stages (S1 operand register, S2 result register); latency from accept to o_valid is exactly 2 cycles when there is no stall.
REQ-022 Handshake: a stage advances when it is empty or its downstream stage advances; o_ready = !S1.valid || S1 advances; throughput is 1 per cycle.
REQ-023 Stability: while o_valid && !i_ready, every S2 output holds its value.
REQ-024 Comparison: BLT/BGE compare signed; BLTU/BGEU compare unsigned; BEQ/BNE test equality.
REQ-025 Illegal funct: taken=0, mispredict=0, illegal=1; the request still flows through the pipe.
REQ-026 Next PC: taken gives i_pc+i_imm; not taken gives i_pc+4; both modulo 2^WIDTH, so they wrap with no error.
REQ-027 Mispredict = legal && ((taken != pred_taken) || (taken && target != pred_target)).
REQ-028 Counters update on an S2 output handshake only: br_count increments for every legal result; mp_count increments for every mispredict; both saturate at all-ones.
REQ-029 Flush: clears the S1 and S2 valid bits at the next edge; a request offered in the same cycle as i_flush is not accepted (o_ready=0 while i_flush=1); counters do not update for flushed entries.
REQ-030 Flush and an output handshake in the same cycle: the handshake counts, then the entry is removed.

Reset
REQ-031 When i_rst is sampled high: S1/S2 valid=0, o_valid=0, o_taken=0, o_mispredict=0, o_illegal=0, o_next_pc=0, both counters=0.
REQ-032 While i_rst is high, o_ready=0.
REQ-033 Reset mid-operation drops every in-flight request without any counter update.
REQ-034 Reset has priority over i_flush and over any handshake.

Structure
REQ-035 t_brop, DATA_SIZE and the funct encodings live in multicore_pkg; a t_br_result struct (taken, next_pc, mispredict, illegal) is added there.
REQ-036 The combinational condition evaluation sits in one sub-module, branch_cond_eval, instantiated between S1 and S2.
REQ-037 Counters and the pipeline registers stay in branch_resolve.

Verification
REQ-038 BLT, r1=-1 (all-ones), r2=1, pred_taken=0, pc=0x100, imm=0x20 -> 2 cycles later: o_taken=1, o_next_pc=0x120, o_mispredict=1, mp_count=1.
REQ-039 BLTU with the same operands -> o_taken=0, o_next_pc=0x104, o_mispredict=0.
REQ-040 Back-to-back 8 BEQ requests with i_ready=0 for cycles 3-5 -> no loss or reorder, outputs stable while stalled, br_count=8.
REQ-041 pc=all-ones minus 3, not taken -> o_next_pc=0; funct=010 -> o_illegal=1, br_count unchanged.
REQ-042 i_flush asserted with both stages full -> o_valid=0 next cycle, counters unchanged; i_rst asserted mid-stream -> all outputs and counters read 0.
REQ-043 mp_count preloaded to all-ones by forcing mispredicts, then one more mispredict -> mp_count stays all-ones.
